// File: rtl/pixel_fetch_ctrl.sv
// Frame sequencer between pixel_pos and the FAST window buffer: position -> memory read -> pixel stream.
// Optional abort/aborted handshake is compiled in when PIXEL_FETCH_ABORT_EN is defined.
module pixel_fetch_ctrl #(
  parameter int SIZE = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [SIZE-1:0]   max_x,
  input  logic [SIZE-1:0]   max_y,
  input  logic [SIZE-1:0]   curr_x,
  input  logic [SIZE-1:0]   curr_y,
  input  logic              next_dir,
  output logic              update_pos,
  output logic              new_trans,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [SIZE-1:0]   pix_x,
  output logic [SIZE-1:0]   pix_y,
  output logic              pix_row_start,
  output logic              pix_last,
  output logic              busy,
`ifdef PIXEL_FETCH_ABORT_EN
  output logic              done,
  input  logic              abort,
  output logic              aborted
`else
  output logic              done
`endif
);

  localparam int CW = 2 * SIZE;

  typedef enum logic [2:0] {IDLE, INIT, CAPT, REQ, OUT, ADV, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     pix_cnt;
  logic [CW-1:0]     last_idx;
  logic              row_flag;
  logic [ADDR_W-1:0] addr_calc;

  assign last_idx  = CW'(max_x) * CW'(max_y) - CW'(1);
  assign addr_calc = BASE_ADDR + ADDR_W'(curr_y) * ADDR_W'(max_x) + ADDR_W'(curr_x);
  assign busy      = (state != IDLE);

`ifdef PIXEL_FETCH_ABORT_EN
  // An abort seen mid-read must wait for the memory to finish before we leave REQ.
  logic abort_pend;
  logic abort_hit;

  assign abort_hit = abort || abort_pend;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      abort_pend <= 1'b0;
    else if (state == REQ)
      abort_pend <= abort_hit && !mem_ack;
    else
      abort_pend <= 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    update_pos = 1'b0;
    new_trans  = 1'b0;
    mem_req    = 1'b0;
    pix_valid  = 1'b0;
    done       = 1'b0;
`ifdef PIXEL_FETCH_ABORT_EN
    aborted    = 1'b0;
`endif
    case (state)
      IDLE: if (start) state_next = (max_x == '0 || max_y == '0) ? DONE : INIT;
      INIT: begin
        update_pos = 1'b1;
        new_trans  = 1'b1;
        state_next = CAPT;
      end
      CAPT: state_next = REQ;
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = OUT;
      end
      OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) state_next = pix_last ? DONE : ADV;
      end
      ADV: begin
        update_pos = 1'b1;
        state_next = CAPT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef PIXEL_FETCH_ABORT_EN
    case (state)
      INIT, CAPT, OUT, ADV: begin
        if (abort) begin
          state_next = IDLE;
          aborted    = 1'b1;
          pix_valid  = 1'b0;
        end
      end
      REQ: begin
        if (mem_ack && abort_hit) begin
          state_next = IDLE;
          aborted    = 1'b1;
        end
      end
      default: ;
    endcase
`endif
  end

  // Read data is only kept when the read actually leads to an output beat.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_cnt       <= '0;
      row_flag      <= 1'b0;
      mem_addr      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      pix_data      <= '0;
      pix_row_start <= 1'b0;
      pix_last      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          pix_cnt  <= '0;
          row_flag <= 1'b1;
        end
        CAPT: begin
          pix_x         <= curr_x;
          pix_y         <= curr_y;
          mem_addr      <= addr_calc;
          pix_row_start <= row_flag;
          pix_last      <= (pix_cnt == last_idx);
        end
        REQ: if (mem_ack && state_next == OUT) pix_data <= mem_rdata;
        ADV: begin
          row_flag <= next_dir;
          pix_cnt  <= pix_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
